// File: rtl/water_level_sensor_decoder_pkg.sv
// Shared definitions for the water level sensor decoder.
//   - state_e      : tank level FSM states (four valid levels plus FAULT)
//   - PAT_*        : the only physically possible float-switch vectors
//   - LVL_*        : 2-bit level codes presented on water_level
//   - decode_pattern / level_to_state / state_to_level : conversion helpers
package water_level_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_LOW    = 3'd1,
    ST_MEDIUM = 3'd2,
    ST_HIGH   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Switches fill from the bottom up, so only "thermometer" vectors are real.
  localparam logic [2:0] PAT_EMPTY  = 3'b000;
  localparam logic [2:0] PAT_LOW    = 3'b001;
  localparam logic [2:0] PAT_MEDIUM = 3'b011;
  localparam logic [2:0] PAT_HIGH   = 3'b111;

  localparam logic [1:0] LVL_EMPTY  = 2'd0;
  localparam logic [1:0] LVL_LOW    = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HIGH   = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] level;
  } level_info_t;

  function automatic level_info_t decode_pattern(input logic [2:0] pat);
    level_info_t info;
    info.valid = 1'b1;
    info.level = LVL_EMPTY;
    case (pat)
      PAT_EMPTY:  info.level = LVL_EMPTY;
      PAT_LOW:    info.level = LVL_LOW;
      PAT_MEDIUM: info.level = LVL_MEDIUM;
      PAT_HIGH:   info.level = LVL_HIGH;
      default:    info.valid = 1'b0;
    endcase
    return info;
  endfunction

  function automatic state_e level_to_state(input logic [1:0] lvl);
    state_e st;
    case (lvl)
      LVL_EMPTY:  st = ST_EMPTY;
      LVL_LOW:    st = ST_LOW;
      LVL_MEDIUM: st = ST_MEDIUM;
      default:    st = ST_HIGH;
    endcase
    return st;
  endfunction

  function automatic logic [1:0] state_to_level(input state_e st);
    logic [1:0] lvl;
    case (st)
      ST_LOW:    lvl = LVL_LOW;
      ST_MEDIUM: lvl = LVL_MEDIUM;
      ST_HIGH:   lvl = LVL_HIGH;
      default:   lvl = LVL_EMPTY;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/water_level_sensor_decoder_sensor_debouncer.sv
// Two-flop synchroniser followed by a whole-vector debouncer.
//   clock    : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   raw_in   : asynchronous sensor vector
//   filtered : last vector that stayed stable for DEBOUNCE_CYCLES+1 samples
module sensor_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] filtered
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] filtered_q, filtered_d;

  always_comb begin
    sync1_d    = raw_in;
    sync2_d    = sync1_q;
    cand_d     = cand_q;
    count_d    = count_q;
    filtered_d = filtered_q;
    // The vector is treated as a unit: a change on any bit restarts the wait.
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      count_d = '0;
    end else if (count_q == COUNT_LAST) begin
      // Counter parks here, so it saturates without extra logic.
      filtered_d = cand_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      count_q    <= '0;
      filtered_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      count_q    <= count_d;
      filtered_q <= filtered_d;
    end
  end

  assign filtered = filtered_q;

endmodule

// File: rtl/water_level_sensor_decoder.sv
// Tank level decoder: debounces the three float switches and tracks the level
// with an FSM that distrusts impossible readings (fail-safe FAULT state).
//   clock                     : system clock, rising edge
//   reset_n                   : synchronous active-low reset
//   water_level_sensors[2:0]  : raw switches (bit0 low .. bit2 high), async
//   water_sensors_conflicting : state is FAULT (valve must close)
//   high_water_level          : state is HIGH
//   low_water_level           : state is EMPTY
//   water_level[1:0]          : last trusted level, held through FAULT
//   level_changed             : one-cycle pulse when water_level changes
module water_level_sensor_decoder
  import water_level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int FAULT_HOLD_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] water_level_sensors,
  output logic       water_sensors_conflicting,
  output logic       high_water_level,
  output logic       low_water_level,
  output logic [1:0] water_level,
  output logic       level_changed
);

  localparam int HOLD_W = $clog2(FAULT_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD_CYCLES - 1);

  logic [2:0]        filtered;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        prev_filtered_q, prev_filtered_d;
  logic              conflicting_q, conflicting_d;
  logic              high_q, high_d;
  logic              low_q, low_d;
  logic [1:0]        level_q, level_d;
  logic              changed_q, changed_d;
  level_info_t       filt_info;
  logic              stable;
  logic              adjacent;

  sensor_debouncer #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_in  (water_level_sensors),
    .filtered(filtered)
  );

  // Next-state logic.
  always_comb begin
    filt_info = decode_pattern(filtered);
    // "Stable" means a valid vector that did not change since last cycle.
    stable    = filt_info.valid && (filtered == prev_filtered_q);
    // level_q is the current level whenever the FSM is in a valid state.
    adjacent  = (filt_info.level == level_q) ||
                ({1'b0, filt_info.level} == {1'b0, level_q} + 3'd1) ||
                ({1'b0, level_q} == {1'b0, filt_info.level} + 3'd1);

    state_d         = state_q;
    hold_d          = '0;
    prev_filtered_d = filtered;

    if (state_q == ST_FAULT) begin
      if (stable) begin
        // Recovery may land on any level; the hold time is what earns trust.
        if (hold_q == HOLD_LAST) begin
          state_d = level_to_state(filt_info.level);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end else if (!filt_info.valid || !adjacent) begin
      state_d = ST_FAULT;
    end else begin
      state_d = level_to_state(filt_info.level);
    end
  end

  // Output logic, computed from the next state so outputs move with the state.
  always_comb begin
    conflicting_d = (state_d == ST_FAULT);
    high_d        = (state_d == ST_HIGH);
    low_d         = (state_d == ST_EMPTY);
    level_d       = level_q;
    if (state_d != ST_FAULT) begin
      level_d = state_to_level(state_d);
    end
    changed_d = (level_d != level_q);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= ST_FAULT;
      hold_q          <= '0;
      prev_filtered_q <= '0;
      conflicting_q   <= 1'b1;
      high_q          <= 1'b0;
      low_q           <= 1'b0;
      level_q         <= LVL_EMPTY;
      changed_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      prev_filtered_q <= prev_filtered_d;
      conflicting_q   <= conflicting_d;
      high_q          <= high_d;
      low_q           <= low_d;
      level_q         <= level_d;
      changed_q       <= changed_d;
    end
  end

  assign water_sensors_conflicting = conflicting_q;
  assign high_water_level          = high_q;
  assign low_water_level           = low_q;
  assign water_level               = level_q;
  assign level_changed             = changed_q;

endmodule

// File: tb/tb_water_level_sensor_decoder.sv
module tb_water_level_sensor_decoder;

  localparam int D = 4;
  localparam int F = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] sensors = 3'b000;
  logic       water_sensors_conflicting;
  logic       high_water_level;
  logic       low_water_level;
  logic [1:0] water_level;
  logic       level_changed;
  logic [5:0] obs;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  logic [2:0] dl[$];    // raw values waiting to become synchronised samples
  logic [2:0] win[$];   // most recent D+1 synchronised samples
  logic [2:0] m_filt, m_filt_old;
  bit         m_fault;
  int         m_level;
  int         m_run;
  bit         m_changed;

  water_level_sensor_decoder #(
    .DEBOUNCE_CYCLES(D),
    .FAULT_HOLD_CYCLES(F)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .water_level_sensors(sensors),
    .water_sensors_conflicting(water_sensors_conflicting),
    .high_water_level(high_water_level),
    .low_water_level(low_water_level),
    .water_level(water_level),
    .level_changed(level_changed)
  );

  always #5 clock = ~clock;

  assign obs = {water_sensors_conflicting, high_water_level, low_water_level,
                water_level, level_changed};

  // A real tank fills bottom-up: valid vectors are 2^k-1, level = number of ones.
  function automatic bit pat_valid(input logic [2:0] p);
    return p == 3'((1 << $countones(p)) - 1);
  endfunction

  function automatic logic [5:0] exp_vec();
    logic [1:0] lv;
    lv = 2'(m_level);
    return {m_fault, (!m_fault && m_level == 3), (!m_fault && m_level == 0), lv, m_changed};
  endfunction

  task automatic model_reset();
    dl.delete();
    dl.push_back(3'b000);
    dl.push_back(3'b000);
    win.delete();
    m_filt = 3'b000;
    m_filt_old = 3'b000;
    m_fault = 1'b1;
    m_level = 0;
    m_run = 0;
    m_changed = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    int old_level, lvl, diff;
    bit all_eq;
    logic [2:0] samp;
    // Tank FSM acts on the debounced value as it stood before this edge.
    old_level = m_level;
    lvl = $countones(m_filt);
    diff = lvl - m_level;
    if (diff < 0) diff = -diff;
    if (!m_fault) begin
      if (!pat_valid(m_filt) || diff > 1) begin
        m_fault = 1'b1;
        m_run = 0;
      end else begin
        m_level = lvl;
      end
    end else if (pat_valid(m_filt) && m_filt == m_filt_old) begin
      m_run++;
      if (m_run == F) begin
        m_fault = 1'b0;
        m_level = lvl;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_changed = (m_level != old_level);
    // Input reaches the debouncer two edges late; accepted after D+1 equal samples.
    samp = dl.pop_front();
    dl.push_back(raw);
    win.push_back(samp);
    if (win.size() > D + 1) void'(win.pop_front());
    m_filt_old = m_filt;
    all_eq = (win.size() == D + 1);
    foreach (win[i]) if (win[i] != win[0]) all_eq = 1'b0;
    if (all_eq) m_filt = win[0];
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge(sensors);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sensors = 3'b011;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (obs !== 6'b100000) $display("FAIL reset_values: got %b want %b", obs, 6'b100000);
    else n_pass++;
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL reset_model: got %b want %b", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_startup();
    int pulses = 0;
    reset_n = 1'b1;
    n_checks++;
    if (water_sensors_conflicting !== 1'b1)
      $display("FAIL startup_conflict_now: got %b want 1", water_sensors_conflicting);
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      pulses += int'(level_changed);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL startup_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 15 || k == 16) begin
        n_checks++;
        if (water_sensors_conflicting !== (k == 15))
          $display("FAIL startup_exit t%0d: got %b want %b", k, water_sensors_conflicting, k == 15);
        else n_pass++;
      end
    end
    n_checks++;
    if ({water_sensors_conflicting, high_water_level, low_water_level, water_level} !== 5'b00010 || pulses != 1)
      $display("FAIL startup_final: got %b pulses %0d want 00010 pulses 1",
               {water_sensors_conflicting, high_water_level, low_water_level, water_level}, pulses);
    else n_pass++;
  endtask

  task automatic test_high();
    sensors = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL high_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k >= 7 && k <= 9) begin
        n_checks++;
        if (obs !== ((k == 7) ? 6'b000100 : (k == 8) ? 6'b010111 : 6'b010110))
          $display("FAIL high_rise t%0d: got %b", k, obs);
        else n_pass++;
      end
    end
    sensors = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL high_fall_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 7 || k == 8) begin
        n_checks++;
        if (high_water_level !== (k == 7))
          $display("FAIL high_fall t%0d: got %b want %b", k, high_water_level, k == 7);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    bit saw_medium;
    sensors = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL glitch_to_low t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
    end
    for (int len = 4; len <= 5; len++) begin
      pulses = 0;
      saw_medium = 1'b0;
      sensors = 3'b011;
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (k == len) sensors = 3'b001;
        pulses += int'(level_changed);
        if (water_level == 2'd2) saw_medium = 1'b1;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL glitch%0d_model t%0d: got %b want %b", len, k, obs, exp_vec());
        else n_pass++;
      end
      n_checks++;
      if (pulses != ((len == 4) ? 0 : 2) || saw_medium != (len == 5) || water_level !== 2'd1)
        $display("FAIL glitch%0d_result: pulses %0d medium %0d level %0d", len, pulses, saw_medium, water_level);
      else n_pass++;
    end
  endtask

  task automatic test_conflict();
    int pulses = 0;
    sensors = 3'b011;
    for (int k = 1; k <= 10; k++) tick();
    n_checks++;
    if (obs !== exp_vec() || water_level !== 2'd2) $display("FAIL conflict_setup: got %b want %b", obs, exp_vec());
    else n_pass++;
    sensors = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      pulses += int'(level_changed);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL conflict_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 7 || k == 8) begin
        n_checks++;
        if (water_sensors_conflicting !== (k == 8) || water_level !== 2'd2)
          $display("FAIL conflict_enter t%0d: got %b lvl %0d", k, water_sensors_conflicting, water_level);
        else n_pass++;
      end
    end
    sensors = 3'b011;
    for (int k = 1; k <= 20; k++) begin
      tick();
      pulses += int'(level_changed);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL conflict_recover_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 15 || k == 16) begin
        n_checks++;
        if (water_sensors_conflicting !== (k == 15))
          $display("FAIL conflict_exit t%0d: got %b want %b", k, water_sensors_conflicting, k == 15);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 0) $display("FAIL conflict_pulses: got %0d want 0", pulses);
    else n_pass++;
  endtask

  task automatic test_skip();
    int pulses = 0;
    sensors = 3'b001;
    for (int k = 1; k <= 10; k++) tick();
    sensors = 3'b000;
    for (int k = 1; k <= 10; k++) tick();
    n_checks++;
    if (obs !== 6'b001000) $display("FAIL skip_empty: got %b want 001000", obs);
    else n_pass++;
    sensors = 3'b111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      pulses += int'(level_changed);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL skip_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 8 || k == 15 || k == 16) begin
        n_checks++;
        if (obs !== ((k == 16) ? 6'b010111 : 6'b100000))
          $display("FAIL skip_seq t%0d: got %b", k, obs);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 1) $display("FAIL skip_pulses: got %0d want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    sensors = 3'b011;
    for (int k = 1; k <= 5; k++) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (obs !== 6'b100000) $display("FAIL midreset_values: got %b want 100000", obs);
    else n_pass++;
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      pulses += int'(level_changed);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL midreset_model t%0d: got %b want %b", k, obs, exp_vec());
      else n_pass++;
      if (k == 15 || k == 16) begin
        n_checks++;
        if (water_sensors_conflicting !== (k == 15))
          $display("FAIL midreset_exit t%0d: got %b want %b", k, water_sensors_conflicting, k == 15);
        else n_pass++;
      end
    end
    n_checks++;
    if (water_level !== 2'd2 || pulses != 1)
      $display("FAIL midreset_final: level %0d pulses %0d want 2 and 1", water_level, pulses);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold, kk;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 3) != 0) begin
        kk = $urandom_range(0, 3);
        sensors = 3'((1 << kk) - 1);
      end else begin
        sensors = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 29) == 0) reset_n = 1'b0;
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        tick();
        reset_n = 1'b1;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL random_model seg%0d t%0d: got %b want %b", seg, k, obs, exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_high();
    test_glitch();
    test_conflict();
    test_skip();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
